// File: rtl/jedro_1_decoder_pkg.sv
// Shared definitions for the jedro_1 decode stage: RV32I opcodes, instruction
// classes, ALU operation encodings, decode FSM states and the decoded-field record.
package jedro_1_defines;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   // Class 0 is reserved for "no class", which is what an illegal decode reports.
   typedef enum logic [3:0] {
      CLS_NONE     = 4'd0,
      CLS_LUI      = 4'd1,
      CLS_AUIPC    = 4'd2,
      CLS_JAL      = 4'd3,
      CLS_JALR     = 4'd4,
      CLS_BRANCH   = 4'd5,
      CLS_LOAD     = 4'd6,
      CLS_STORE    = 4'd7,
      CLS_OP_IMM   = 4'd8,
      CLS_OP       = 4'd9,
      CLS_MISC_MEM = 4'd10,
      CLS_SYSTEM   = 4'd11
   } instr_class_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SLL  = 4'h1,
      ALU_SLT  = 4'h2,
      ALU_SLTU = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_SRL  = 4'h5,
      ALU_OR   = 4'h6,
      ALU_AND  = 4'h7,
      ALU_SUB  = 4'h8,
      ALU_SRA  = 4'hD
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_HALT  = 2'd2
   } dec_state_e;

   typedef struct packed {
      instr_class_e      cls;
      logic [3:0]        alu_op;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              rd_we;
      logic              use_imm;
      logic [XLEN-1:0]   imm;
   } dec_fields_t;

   function automatic logic class_writes_rd(instr_class_e c);
      return c inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD, CLS_OP_IMM, CLS_OP};
   endfunction

endpackage

// File: rtl/jedro_1_decoder_if.sv
// Decode-stage bus: IFU fetch handshake on one side, execute-stage handshake and
// decoded fields on the other. The decoder takes the slave view.
interface jedro_1_decoder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
);
   logic [DATA_WIDTH-1:0] cinstr_i;
   logic                  cinstr_valid_i;
   logic                  get_next_instr_o;
   logic                  flush_i;
   logic                  ex_ready_i;
   logic                  dec_valid_o;
   logic [3:0]            instr_class_o;
   logic [3:0]            alu_op_o;
   logic [REG_ADDR_W-1:0] rs1_addr_o;
   logic [REG_ADDR_W-1:0] rs2_addr_o;
   logic [REG_ADDR_W-1:0] rd_addr_o;
   logic                  rd_we_o;
   logic                  use_imm_o;
   logic [DATA_WIDTH-1:0] imm_o;
   logic                  illegal_instr_o;

   modport slave (
      input  cinstr_i, cinstr_valid_i, flush_i, ex_ready_i,
      output get_next_instr_o, dec_valid_o, instr_class_o, alu_op_o,
             rs1_addr_o, rs2_addr_o, rd_addr_o, rd_we_o, use_imm_o,
             imm_o, illegal_instr_o
   );

   modport master (
      output cinstr_i, cinstr_valid_i, flush_i, ex_ready_i,
      input  get_next_instr_o, dec_valid_o, instr_class_o, alu_op_o,
             rs1_addr_o, rs2_addr_o, rd_addr_o, rd_we_o, use_imm_o,
             imm_o, illegal_instr_o
   );
endinterface

// File: rtl/jedro_1_decoder_imm_gen.sv
// RV32I immediate generator: picks the I/S/B/U/J format from the opcode and
// sign-extends from instr[31]. Formats without an immediate produce 0.
module jedro_1_imm_gen
   import jedro_1_defines::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm
);

   logic [6:0] opcode;
   assign opcode = instr[6:0];

   // NOTE: imm gets a default before the case so every path assigns it and no latch is inferred.
   always_comb begin
      imm = '0;
      case (opcode)
         OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM:
            imm = {{20{instr[31]}}, instr[31:20]};
         OPC_STORE:
            imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OPC_BRANCH:
            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm = {instr[31:12], 12'h000};
         OPC_JAL:
            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:
            imm = '0;
      endcase
   end

endmodule

// File: rtl/jedro_1_decoder.sv
// RV32I decode stage: combinational decode of the IFU word into a single output
// register, sequenced by an EMPTY/FULL/HALT FSM with flush from execute.
module jedro_1_decoder
   import jedro_1_defines::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input logic              clk_i,
   input logic              rstn_i,
   jedro_1_decoder_if.slave dec_if
);

   logic [DATA_WIDTH-1:0] instr;
   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [REG_ADDR_W-1:0] rs1_field;
   logic [REG_ADDR_W-1:0] rs2_field;
   logic [REG_ADDR_W-1:0] rd_field;
   logic [31:0]           imm_w;

   instr_class_e cls;
   logic         dec_illegal;
   dec_fields_t  dec;
   dec_fields_t  held;

   dec_state_e state;
   dec_state_e state_nxt;

   logic accept;
   logic retire;
   logic get_next;
   logic dec_valid;

   assign instr     = dec_if.cinstr_i;
   assign opcode    = instr[6:0];
   assign funct3    = instr[14:12];
   assign funct7    = instr[31:25];
   assign rs1_field = instr[15 +: REG_ADDR_W];
   assign rs2_field = instr[20 +: REG_ADDR_W];
   assign rd_field  = instr[7 +: REG_ADDR_W];

   jedro_1_imm_gen u_imm_gen (
      .instr (instr),
      .imm   (imm_w)
   );

   // Class and legality. Opcodes not ending in 2'b11 never match a legal opcode.
   always_comb begin
      cls         = CLS_NONE;
      dec_illegal = 1'b0;
      case (opcode)
         OPC_LUI:      cls = CLS_LUI;
         OPC_AUIPC:    cls = CLS_AUIPC;
         OPC_JAL:      cls = CLS_JAL;
         OPC_JALR:     cls = CLS_JALR;
         OPC_BRANCH:   cls = CLS_BRANCH;
         OPC_LOAD:     cls = CLS_LOAD;
         OPC_STORE:    cls = CLS_STORE;
         OPC_MISC_MEM: cls = CLS_MISC_MEM;
         OPC_SYSTEM:   cls = CLS_SYSTEM;
         OPC_OP_IMM: begin
            cls = CLS_OP_IMM;
            if (funct3 == 3'd1 && funct7 != F7_BASE)
               dec_illegal = 1'b1;
            if (funct3 == 3'd5 && !(funct7 inside {F7_BASE, F7_ALT}))
               dec_illegal = 1'b1;
         end
         OPC_OP: begin
            cls = CLS_OP;
            if (funct7 == F7_ALT)
               dec_illegal = !(funct3 inside {3'd0, 3'd5});
            else if (funct7 != F7_BASE)
               dec_illegal = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // Field packing; an illegal word leaves every field at zero.
   always_comb begin
      dec = '0;
      if (!dec_illegal) begin
         dec.cls     = cls;
         dec.rs1     = rs1_field;
         dec.rs2     = rs2_field;
         dec.rd      = rd_field;
         dec.imm     = imm_w;
         dec.use_imm = !(cls inside {CLS_OP, CLS_BRANCH});
         dec.rd_we   = class_writes_rd(cls) && (rd_field != '0);
         if (cls == CLS_OP)
            dec.alu_op = {funct7[5], funct3};
         else if (cls == CLS_OP_IMM)
            dec.alu_op = {(funct3 == 3'd5) & funct7[5], funct3};
         else
            dec.alu_op = ALU_ADD;
      end
   end

   assign accept = dec_if.cinstr_valid_i & get_next;
   assign retire = dec_valid & dec_if.ex_ready_i;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rstn_i)
         state <= ST_EMPTY;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (dec_if.flush_i) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY:
               if (accept)
                  state_nxt = dec_illegal ? ST_HALT : ST_FULL;
            ST_FULL:
               if (retire && accept)
                  state_nxt = dec_illegal ? ST_HALT : ST_FULL;
               else if (retire)
                  state_nxt = ST_EMPTY;
            ST_HALT:
               state_nxt = ST_HALT;
            default:
               state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      dec_valid = (state != ST_EMPTY);
      get_next  = rstn_i && !dec_if.flush_i &&
                  ((state == ST_EMPTY) || (state == ST_FULL && dec_if.ex_ready_i));
   end

   // NOTE: the field register is reset because execute must see all-zero outputs during reset.
   always_ff @(posedge clk_i) begin
      if (!rstn_i)
         held <= '0;
      else if (accept)
         held <= dec;
   end

   assign dec_if.get_next_instr_o = get_next;
   assign dec_if.dec_valid_o      = dec_valid;
   assign dec_if.illegal_instr_o  = (state == ST_HALT);
   assign dec_if.instr_class_o    = held.cls;
   assign dec_if.alu_op_o         = held.alu_op;
   assign dec_if.rs1_addr_o       = held.rs1;
   assign dec_if.rs2_addr_o       = held.rs2;
   assign dec_if.rd_addr_o        = held.rd;
   assign dec_if.rd_we_o          = held.rd_we;
   assign dec_if.use_imm_o        = held.use_imm;
   assign dec_if.imm_o            = held.imm;

endmodule

// File: tb/tb_jedro_1_decoder.sv
// Scoreboard bench for jedro_1_decoder: directed scenarios then random traffic,
// checked against an ISA-level reference model.
module tb_jedro_1_decoder;
   import jedro_1_defines::*;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   jedro_1_decoder_if dif ();

   jedro_1_decoder dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .dec_if (dif)
   );

   typedef struct {
      logic [3:0]  cls;
      logic [3:0]  alu;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rd_we;
      logic        use_imm;
      logic [31:0] imm;
      logic        illegal;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ISA-level model: what the instruction means, not how the decoder is built.
   function automatic exp_t model(logic [31:0] w);
      exp_t               e;
      logic [6:0]         op = w[6:0];
      logic [2:0]         f3 = w[14:12];
      logic [6:0]         f7 = w[31:25];
      logic signed [31:0] s  = $signed(w);
      logic [31:0]        imm_i, imm_s, imm_b, imm_u, imm_j;
      logic               bad = 1'b0;
      logic               writes = 1'b0;
      imm_i = 32'(s >>> 20);
      imm_s = (32'(s >>> 25) << 5) | 32'(w[11:7]);
      imm_b = (32'(s >>> 31) << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      imm_u = w & 32'hFFFF_F000;
      imm_j = (32'(s >>> 31) << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      e = '{cls: 4'd0, alu: 4'd0, rs1: w[19:15], rs2: w[24:20], rd: w[11:7],
            rd_we: 1'b0, use_imm: 1'b1, imm: 32'd0, illegal: 1'b0};
      case (op)
         OPC_LUI:      begin e.cls = CLS_LUI;      e.imm = imm_u; writes = 1'b1; end
         OPC_AUIPC:    begin e.cls = CLS_AUIPC;    e.imm = imm_u; writes = 1'b1; end
         OPC_JAL:      begin e.cls = CLS_JAL;      e.imm = imm_j; writes = 1'b1; end
         OPC_JALR:     begin e.cls = CLS_JALR;     e.imm = imm_i; writes = 1'b1; end
         OPC_BRANCH:   begin e.cls = CLS_BRANCH;   e.imm = imm_b; e.use_imm = 1'b0; end
         OPC_LOAD:     begin e.cls = CLS_LOAD;     e.imm = imm_i; writes = 1'b1; end
         OPC_STORE:    begin e.cls = CLS_STORE;    e.imm = imm_s; end
         OPC_MISC_MEM: begin e.cls = CLS_MISC_MEM; e.imm = imm_i; end
         OPC_SYSTEM:   begin e.cls = CLS_SYSTEM;   e.imm = imm_i; end
         OPC_OP_IMM: begin
            e.cls = CLS_OP_IMM; e.imm = imm_i; writes = 1'b1;
            e.alu = (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
            if (f3 == 3'd1 && f7 != 7'h00) bad = 1'b1;
            if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
         end
         OPC_OP: begin
            e.cls = CLS_OP; e.use_imm = 1'b0; writes = 1'b1;
            e.alu = {f7[5], f3};
            if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) bad = 1'b1;
         end
         default: bad = 1'b1;
      endcase
      e.rd_we = writes && (w[11:7] != 5'd0);
      if (bad)
         e = '{cls: 4'd0, alu: 4'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
               rd_we: 1'b0, use_imm: 1'b0, imm: 32'd0, illegal: 1'b1};
      return e;
   endfunction

   // Inputs change just after the rising edge; the accept decision is read at the falling edge.
   task automatic drive(logic [31:0] instr, logic v, logic r, logic f, logic rn = 1'b1);
      @(posedge clk);
      #1;
      rstn               = rn;
      dif.cinstr_i       = instr;
      dif.cinstr_valid_i = v;
      dif.ex_ready_i     = r;
      dif.flush_i        = f;
      @(negedge clk);
      #1;
      if (rstn && dif.cinstr_valid_i && dif.get_next_instr_o)
         sb.push_back(model(instr));
   endtask

   // Monitor: checks handshake and held fields every cycle, pops on retire or flush.
   initial begin : monitor
      logic prev_rst_low = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            check("get_next_in_reset", 32'(dif.get_next_instr_o), 32'd0);
            if (prev_rst_low) begin
               check("rst_dec_valid", 32'(dif.dec_valid_o), 32'd0);
               check("rst_illegal", 32'(dif.illegal_instr_o), 32'd0);
               check("rst_fields", {dif.instr_class_o, dif.alu_op_o, dif.rs1_addr_o, dif.rs2_addr_o,
                                    dif.rd_addr_o, dif.rd_we_o, dif.use_imm_o}, 32'd0);
               check("rst_imm", dif.imm_o, 32'd0);
            end
            sb.delete();
            prev_rst_low = 1'b1;
         end else begin
            prev_rst_low = 1'b0;
            check("dec_valid", 32'(dif.dec_valid_o), 32'(sb.size() != 0));
            check("get_next", 32'(dif.get_next_instr_o),
                  32'(!dif.flush_i && (sb.size() == 0 || (!sb[0].illegal && dif.ex_ready_i))));
            if (sb.size() != 0 && dif.dec_valid_o) begin
               e = sb[0];
               check("class", 32'(dif.instr_class_o), 32'(e.cls));
               check("alu_op", 32'(dif.alu_op_o), 32'(e.alu));
               check("regs", {dif.rs1_addr_o, dif.rs2_addr_o, dif.rd_addr_o}, {e.rs1, e.rs2, e.rd});
               check("rd_we", 32'(dif.rd_we_o), 32'(e.rd_we));
               check("use_imm", 32'(dif.use_imm_o), 32'(e.use_imm));
               check("imm", dif.imm_o, e.imm);
               check("illegal", 32'(dif.illegal_instr_o), 32'(e.illegal));
            end
            if (sb.size() != 0) begin
               if (dif.flush_i)
                  void'(sb.pop_front());
               else if (dif.ex_ready_i && !sb[0].illegal)
                  void'(sb.pop_front());
            end
         end
      end
   end

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops[11] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                                OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM};
      logic [31:0] w = $urandom;
      if ($urandom_range(9) < 8) begin
         w[6:0] = ops[$urandom_range(10)];
         case ($urandom_range(3))
            0, 1: w[31:25] = 7'h00;
            2:    w[31:25] = 7'h20;
            default: ;
         endcase
      end
      return w;
   endfunction

   localparam logic [31:0] I_ADDI5  = 32'h0050_0093;
   localparam logic [31:0] I_ADD    = 32'h0020_81B3;
   localparam logic [31:0] I_SUB    = 32'h4020_8233;
   localparam logic [31:0] I_LUI    = 32'h1234_52B7;
   localparam logic [31:0] I_ADDI3  = 32'h0030_8213;
   localparam logic [31:0] I_ILL    = 32'hFFFF_FFFF;
   localparam logic [31:0] I_ADDIM1 = 32'hFFF0_0113;
   localparam logic [31:0] I_NOP    = 32'h0000_0013;

   initial begin : stimulus
      rstn               = 1'b0;
      dif.cinstr_i       = I_ADDI5;
      dif.cinstr_valid_i = 1'b1;
      dif.ex_ready_i     = 1'b1;
      dif.flush_i        = 1'b0;

      repeat (3) drive(I_ADDI5, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("get_next_after_reset", 32'(dif.get_next_instr_o), 32'd1);

      drive(I_ADDI5, 1'b1, 1'b0, 1'b0);
      drive(32'd0, 1'b0, 1'b0, 1'b0);
      check("addi_class", 32'(dif.instr_class_o), 32'(CLS_OP_IMM));
      check("addi_rd_rs1", {dif.rd_addr_o, dif.rs1_addr_o}, {5'd1, 5'd0});
      check("addi_imm", dif.imm_o, 32'd5);
      check("addi_flags", {dif.use_imm_o, dif.rd_we_o, dif.alu_op_o}, {1'b1, 1'b1, 4'h0});
      drive(32'd0, 1'b0, 1'b1, 1'b0);

      drive(I_ADD, 1'b1, 1'b1, 1'b0);
      drive(I_SUB, 1'b1, 1'b1, 1'b0);
      check("stream_add_alu", 32'(dif.alu_op_o), 32'h0);
      drive(I_LUI, 1'b1, 1'b1, 1'b0);
      check("stream_sub_alu", 32'(dif.alu_op_o), 32'h8);
      drive(32'd0, 1'b0, 1'b1, 1'b0);
      check("stream_lui_alu", 32'(dif.alu_op_o), 32'h0);
      check("stream_lui_imm", dif.imm_o, 32'h1234_5000);

      drive(I_ADDI5, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(I_ADDI3, 1'b1, 1'b0, 1'b0);
         check("stall_get_next", 32'(dif.get_next_instr_o), 32'd0);
         check("stall_imm_stable", dif.imm_o, 32'd5);
      end
      drive(I_ADDI3, 1'b1, 1'b1, 1'b0);
      drive(32'd0, 1'b0, 1'b1, 1'b0);
      check("after_stall_imm", dif.imm_o, 32'd3);
      check("after_stall_rd", 32'(dif.rd_addr_o), 32'd4);

      drive(I_ILL, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(I_ADDI5, 1'b1, 1'b1, 1'b0);
         check("halt_state", {dif.dec_valid_o, dif.illegal_instr_o, dif.get_next_instr_o}, 3'b110);
      end
      drive(32'd0, 1'b1, 1'b1, 1'b1);
      drive(I_ADDI5, 1'b1, 1'b1, 1'b0);
      check("post_halt_flush", {dif.dec_valid_o, dif.illegal_instr_o, dif.get_next_instr_o}, 3'b001);

      drive(I_ADD, 1'b1, 1'b1, 1'b1);
      check("flush_blocks_accept", {dif.dec_valid_o, dif.get_next_instr_o}, 2'b10);
      drive(32'd0, 1'b0, 1'b0, 1'b0);
      check("flush_drops_held", 32'(dif.dec_valid_o), 32'd0);

      drive(I_ADDIM1, 1'b1, 1'b1, 1'b0);
      drive(I_NOP, 1'b1, 1'b1, 1'b0);
      check("addi_m1_imm", dif.imm_o, 32'hFFFF_FFFF);
      drive(32'd0, 1'b0, 1'b1, 1'b0);
      check("nop_rd_we", {dif.rd_we_o, dif.instr_class_o}, {1'b0, 4'(CLS_OP_IMM)});

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(299) == 0) begin
            drive(rand_instr(), 1'b1, 1'b1, 1'b0, 1'b0);
            drive(rand_instr(), 1'b1, 1'b1, 1'b0, 1'b0);
         end else begin
            drive(rand_instr(), 1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0),
                  1'($urandom_range(15) == 0));
         end
      end

      drive(32'd0, 1'b0, 1'b1, 1'b1);
      drive(32'd0, 1'b0, 1'b1, 1'b0);
      drive(32'd0, 1'b0, 1'b1, 1'b0);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
